// File: rtl/jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_ctrl
// Purpose  : Round-robin controller sharing one bank of WIDTH external JK
//            flip-flops among NREQ requesters. Each request (read, reset,
//            set, toggle on one bit) is applied to the bank for exactly one
//            clock, the resulting q is sampled, and it is returned with a
//            one-cycle acknowledge.
// Ports    : clk     - clock, rising edge
//            rst     - asynchronous active-low reset
//            req     - per-requester request level, held until ack
//            op      - per-requester op, 2 bits each (00 rd,01 rst,10 set,11 tgl)
//            idx     - per-requester target bit index, IDXW bits each
//            ack     - one-hot completion pulse
//            rdata   - targeted q after the operation, valid with ack
//            err     - granted index was out of range, valid with ack
//            busy    - controller is not idle
//            gnt_id  - requester currently being served
//            jk_j    - to bank j inputs
//            jk_k    - to bank k inputs
//            jk_q    - from bank q outputs
// Revision : 1.0 - initial release
// ============================================================================
module jk_bank_ctrl #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [2*NREQ-1:0]         op,
  input  logic [IDXW*NREQ-1:0]      idx,
  output logic [NREQ-1:0]           ack,
  output logic                      rdata,
  output logic                      err,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic [WIDTH-1:0]          jk_j,
  output logic [WIDTH-1:0]          jk_k,
  input  logic [WIDTH-1:0]          jk_q
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CAPT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q,  state_d;
  logic [GW-1:0]       ptr_q,    ptr_d;
  logic [GW-1:0]       gnt_id_q, gnt_id_d;
  logic [1:0]          op_q,     op_d;
  logic [IDXW-1:0]     idx_q,    idx_d;
  logic [NREQ-1:0]     ack_q,    ack_d;
  logic                rdata_q,  rdata_d;
  logic                err_q,    err_d;
  logic                busy_q,   busy_d;
  logic [WIDTH-1:0]    jk_j_q,   jk_j_d;
  logic [WIDTH-1:0]    jk_k_q,   jk_k_d;

  // Round-robin winner selection
  logic                found;
  logic [GW-1:0]       win_id;
  logic [1:0]          win_op;
  logic [IDXW-1:0]     win_idx;
  logic [GW:0]         cand_sum;
  logic [GW-1:0]       cand;

  always_comb begin
    found    = 1'b0;
    win_id   = '0;
    win_op   = '0;
    win_idx  = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      // One extra bit so the modulo-NREQ wrap works for non-power-of-two NREQ
      cand_sum = {1'b0, ptr_q} + (GW+1)'(k);
      if (cand_sum >= (GW+1)'(NREQ)) begin
        cand_sum = cand_sum - (GW+1)'(NREQ);
      end
      cand = cand_sum[GW-1:0];
      // Constant-index selects: scan every requester and match the candidate
      for (int r = 0; r < NREQ; r++) begin
        if (!found && (cand == GW'(r)) && req[r]) begin
          found   = 1'b1;
          win_id  = cand;
          win_op  = op[2*r +: 2];
          win_idx = idx[IDXW*r +: IDXW];
        end
      end
    end
  end

  // Next-state and registered-output logic
  logic hit;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    op_d     = op_q;
    idx_d    = idx_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    jk_j_d   = '0;
    jk_k_d   = '0;
    hit      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_APPLY;
          gnt_id_d = win_id;
          op_d     = win_op;
          idx_d    = win_idx;
          ptr_d    = (win_id == GW'(NREQ-1)) ? '0 : win_id + GW'(1);
          // j = op[1], k = op[0]; an out-of-range index matches no bit,
          // so nothing is driven for it
          for (int i = 0; i < WIDTH; i++) begin
            if (win_idx == IDXW'(i)) begin
              jk_j_d[i] = win_op[1];
              jk_k_d[i] = win_op[0];
            end
          end
        end
      end
      S_APPLY: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        state_d         = S_DONE;
        ack_d[gnt_id_q] = 1'b1;
        rdata_d         = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
          if (idx_q == IDXW'(i)) begin
            hit     = 1'b1;
            rdata_d = jk_q[i];
          end
        end
        err_d = ~hit;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      ack_q    <= '0;
      rdata_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      jk_j_q   <= '0;
      jk_k_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      jk_j_q   <= jk_j_d;
      jk_k_q   <= jk_k_d;
    end
  end

  assign ack    = ack_q;
  assign rdata  = rdata_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign gnt_id = gnt_id_q;
  assign jk_j   = jk_j_q;
  assign jk_k   = jk_k_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bank_ctrl
// Purpose  : Self-checking bench for jk_bank_ctrl. A behavioural JK bank is
//            attached to each DUT; expected acknowledges are queued when a
//            request is issued and compared when the DUT acknowledges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_bank_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: NREQ=4, WIDTH=8
  logic [3:0]  req = '0;
  logic [7:0]  op  = '0;
  logic [11:0] idx = '0;
  logic [3:0]  ack;
  logic        rdata, err, busy;
  logic [1:0]  gnt_id;
  logic [7:0]  jk_j, jk_k, jk_q;

  // Second DUT: WIDTH=6 for out-of-range indices
  logic [3:0]  req6 = '0;
  logic [7:0]  op6  = '0;
  logic [11:0] idx6 = '0;
  logic [3:0]  ack6;
  logic        rdata6, err6, busy6;
  logic [1:0]  gnt6;
  logic [5:0]  j6, k6, q6;

  jk_bank_ctrl #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy), .gnt_id(gnt_id),
    .jk_j(jk_j), .jk_k(jk_k), .jk_q(jk_q)
  );

  jk_bank_ctrl #(.NREQ(4), .WIDTH(6)) dut6 (
    .clk(clk), .rst(rst), .req(req6), .op(op6), .idx(idx6),
    .ack(ack6), .rdata(rdata6), .err(err6), .busy(busy6), .gnt_id(gnt6),
    .jk_j(j6), .jk_k(k6), .jk_q(q6)
  );

  // Behavioural JK banks sharing the controller reset
  logic [7:0] bank  = '0;
  logic [5:0] bank6 = '0;
  assign jk_q = bank;
  assign q6   = bank6;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        case ({jk_j[i], jk_k[i]})
          2'b01:   bank[i] <= 1'b0;
          2'b10:   bank[i] <= 1'b1;
          2'b11:   bank[i] <= ~bank[i];
          default: ;
        endcase
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank6 <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        case ({j6[i], k6[i]})
          2'b01:   bank6[i] <= 1'b0;
          2'b10:   bank6[i] <= 1'b1;
          2'b11:   bank6[i] <= ~bank6[i];
          default: ;
        endcase
      end
    end
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard
  typedef struct packed {
    logic [3:0] ack;
    logic       rdata;
    logic       err;
  } exp_t;
  exp_t sb[$];
  logic [7:0] shadow = '0;

  task automatic push_expected(input int id, input logic [1:0] o, input logic [2:0] ix);
    exp_t e;
    case (o)
      2'b01:   shadow[ix] = 1'b0;
      2'b10:   shadow[ix] = 1'b1;
      2'b11:   shadow[ix] = ~shadow[ix];
      default: ;
    endcase
    e.ack     = '0;
    e.ack[id] = 1'b1;
    e.rdata   = shadow[ix];
    e.err     = 1'b0;
    sb.push_back(e);
  endtask

  // Output monitor: scoreboard compare on ack, j/k shape checks every cycle
  logic prev_nz = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (ack !== '0) begin
      if (sb.size() == 0) begin
        check_val("unexpected_ack", ack, 0);
      end else begin
        e = sb.pop_front();
        check_val("ack_id", ack, e.ack);
        check_val("rdata", rdata, e.rdata);
        check_val("err", err, e.err);
      end
    end
    if ((jk_j | jk_k) !== '0) begin
      check_val("jk_onehot", $countones(jk_j | jk_k), 1);
      check_val("jk_one_clock", prev_nz, 0);
    end
    prev_nz <= ((jk_j | jk_k) !== '0);
  end

  // Single request from one requester; checks the APPLY/CAPT drive and latency
  task automatic do_op(input int id, input logic [1:0] o, input logic [2:0] ix);
    logic [7:0] ej, ek;
    int lat;
    @(negedge clk);
    op[2*id +: 2]  = o;
    idx[3*id +: 3] = ix;
    req[id]        = 1'b1;
    push_expected(id, o, ix);
    ej = '0;
    ek = '0;
    case (o)
      2'b01: ek[ix] = 1'b1;
      2'b10: ej[ix] = 1'b1;
      2'b11: begin ej[ix] = 1'b1; ek[ix] = 1'b1; end
      default: ;
    endcase
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check_val("apply_j", jk_j, ej);
        check_val("apply_k", jk_k, ek);
        check_val("busy_apply", busy, 1);
        check_val("gnt_id", gnt_id, id);
      end
      if (c == 2) check_val("capt_jk", jk_j | jk_k, 0);
      if (ack !== '0) lat = c;
    end
    check_val("latency", lat, 3);
    req[id] = 1'b0;
  endtask

  // Wait for n acks; checks 4-cycle spacing, optionally drops acked requests
  task automatic wait_acks(input int n, input bit drop);
    int got  = 0;
    int last = -1;
    for (int c = 0; c < 20*n && got < n; c++) begin
      @(negedge clk);
      if (ack !== '0) begin
        if (last >= 0) check_val("ack_gap", cyc - last, 4);
        last = cyc;
        got++;
        if (drop) req = req & ~ack;
      end
    end
    check_val("ack_count", got, n);
  endtask

  task automatic do_op6(input int id, input logic [1:0] o, input logic [2:0] ix,
                        input logic ee, input logic er, input logic [5:0] ejk);
    logic [5:0] acc;
    logic [3:0] ea;
    int lat;
    @(negedge clk);
    op6[2*id +: 2]  = o;
    idx6[3*id +: 3] = ix;
    req6[id]        = 1'b1;
    acc = '0;
    ea  = '0;
    ea[id] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      acc = acc | j6 | k6;
      if (ack6 !== '0) begin
        lat = c;
        check_val("w6_ack", ack6, ea);
        check_val("w6_err", err6, ee);
        check_val("w6_rdata", rdata6, er);
      end
    end
    check_val("w6_latency", lat, 3);
    check_val("w6_jk", acc, ejk);
    req6[id] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    shadow = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    // Reset held with every requester asking: nothing may happen
    rst = 1'b0;
    op  = {2'b01, 2'b10, 2'b11, 2'b10};       // r3 reset, r2 set, r1 toggle, r0 set
    idx = {3'd0, 3'd7, 3'd1, 3'd0};
    req = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check_val("rst_ack", ack, 0);
      check_val("rst_jk", jk_j | jk_k, 0);
      check_val("rst_busy", busy, 0);
    end
    check_val("rst_rdata", rdata, 0);
    check_val("rst_err", err, 0);
    check_val("rst_gnt", gnt_id, 0);

    // Fairness from ptr=0 with all requests held
    push_expected(0, 2'b10, 3'd0);
    push_expected(1, 2'b11, 3'd1);
    push_expected(2, 2'b10, 3'd7);
    push_expected(3, 2'b01, 3'd0);
    push_expected(0, 2'b10, 3'd0);
    rst = 1'b1;
    wait_acks(5, 1'b0);
    req = '0;

    // Single set from reset
    pulse_reset();
    do_op(1, 2'b10, 3'd3);

    // Toggle twice, reset, set/read
    do_op(2, 2'b11, 3'd5);
    do_op(2, 2'b11, 3'd5);
    do_op(2, 2'b01, 3'd5);
    do_op(2, 2'b00, 3'd5);
    do_op(2, 2'b10, 3'd2);
    do_op(2, 2'b00, 3'd2);

    // Mid-op reset: ptr is 3, so requester 3 wins first
    @(negedge clk);
    op[2*1 +: 2]  = 2'b10; idx[3*1 +: 3] = 3'd6;
    op[2*3 +: 2]  = 2'b10; idx[3*3 +: 3] = 3'd4;
    req = 4'b1010;
    @(negedge clk);
    check_val("mid_gnt", gnt_id, 3);
    check_val("mid_apply_j", jk_j, 8'h10);
    rst = 1'b0;
    shadow = '0;
    #1;
    check_val("mid_async_jk", jk_j | jk_k, 0);
    check_val("mid_async_busy", busy, 0);
    repeat (2) begin
      @(negedge clk);
      check_val("mid_no_ack", ack, 0);
    end
    push_expected(1, 2'b10, 3'd6);
    push_expected(3, 2'b10, 3'd4);
    rst = 1'b1;
    wait_acks(2, 1'b1);
    req = '0;
    check_val("bank_after_mid", bank, 8'h50);

    // Out-of-range index on the WIDTH=6 instance, then an in-range one
    do_op6(3, 2'b10, 3'd7, 1'b1, 1'b0, 6'b000000);
    do_op6(0, 2'b10, 3'd5, 1'b0, 1'b1, 6'b100000);

    repeat (4) @(negedge clk);
    check_val("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Round-robin controller that shares one bank of `WIDTH` external `jk_ff` flip-flops among `NREQ` requesters. Each requester asks for one operation (read, reset, set, toggle) on one bit; the controller arbitrates, drives the bank's `j`/`k` inputs for exactly one clock, samples the resulting `q`, and returns it with a one-cycle acknowledge. It sits between requester logic and the flip-flop bank and is the only driver of the bank's `j`/`k` inputs.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `WIDTH`, 8, number of flip-flops in the bank (2..32)
- `IDXW`, `$clog2(WIDTH)`, bit-index width (derived; not overridden)
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — one clock; reset is asynchronous and active-low
- `req` input NREQ — per-requester request level, held until `ack`
- `op` input 2*NREQ — requester r's op at `[2r+1:2r]`: 00 read, 01 reset (j0k1), 10 set (j1k0), 11 toggle (j1k1)
- `idx` input IDXW*NREQ — requester r's target bit at `[IDXW*r +: IDXW]`
- `ack` output NREQ — one-hot, one-cycle completion pulse
- `rdata` output 1 — value of the targeted `q` after the operation; valid while `ack` is high
- `err` output 1 — high with `ack` when the granted `idx` ≥ `WIDTH`
- `busy` output 1 — high in any state other than IDLE
- `gnt_id` output `$clog2(NREQ)` — index of the requester currently being served
- `jk_j` output WIDTH — to bank `j` inputs
- `jk_k` output WIDTH — to bank `k` inputs
- `jk_q` input WIDTH — from bank `q` outputs

## Operation
- FSM: IDLE → APPLY → CAPT → DONE → IDLE.
- IDLE: if `|req`, pick a winner by round-robin, latch its `op`, `idx` and id into internal registers, go to APPLY; otherwise stay in IDLE.
- Round-robin: search starts at `ptr` and wraps modulo NREQ; the first asserted `req` wins; `ptr` ← winner+1 (wraps to 0 after NREQ-1). `ptr` = 0 after reset.
- APPLY: `jk_j`/`jk_k` carry the latched op's j/k values on bit `idx` only; all other bits are 0. A read op drives 0/0, so the bank holds.
- CAPT: `jk_j` = `jk_k` = 0; `jk_q[idx]` is sampled into `rdata`.
- DONE: `ack[gnt_id]` = 1, `rdata` and `err` valid; return to IDLE.
- Out-of-range `idx` (≥ WIDTH): no `j`/`k` bit is driven, `rdata` = 0, `err` = 1 in DONE.
- `req` changes outside IDLE are ignored; operands are latched only in IDLE.
- Requester protocol: keep `req` high until `ack` is seen and drop it on the following edge. A `req` still high in the IDLE after DONE is treated as a new request.

## Timing
- All outputs are registered. Reset values: `ack` = 0, `rdata` = 0, `err` = 0, `busy` = 0, `gnt_id` = 0, `jk_j` = 0, `jk_k` = 0, state = IDLE, `ptr` = 0.
- Latency: `req` sampled high at edge E0 → APPLY during E0..E1 → the bank updates at E1 → CAPT samples `q` at E2 → `ack` is high from E2 to E3.
- Throughput: one operation per 4 cycles; a back-to-back winner is picked in the IDLE cycle following DONE.
- `j`/`k` are non-zero for exactly one clock per operation, and never on more than one bit.
- Asynchronous reset mid-operation: outputs go to their reset values immediately and the operation is dropped with no `ack`. The bank's own reset is tied to the same `rst`.
- `busy` is high in APPLY, CAPT and DONE.

## Test plan
- Reset: hold `rst` = 0 with all `req` high → `ack`, `jk_j`, `jk_k`, `busy` stay 0. Release → requester 0 is served first.
- Single set: req[1], op = 10, idx = 3 from reset → `jk_j` = 8'h08 and `jk_k` = 0 for one cycle; `ack` = 4'b0010 three cycles after the sampled request; `rdata` = 1.
- Toggle then reset: req[2] toggles bit 5 twice → `rdata` = 1, then 0. Reset op on bit 5 → `rdata` = 0 and bit 5 holds 0. A read op gives `jk_j` = `jk_k` = 0 and returns the current `q`.
- Fairness: all four `req` held high continuously → `ack` order is 0, 1, 2, 3, 0, each 4 cycles apart.
- Out of range: `WIDTH` = 6, idx = 7 → no `jk_j`/`jk_k` bit set; `err` = 1, `rdata` = 0 with `ack`.
- Mid-op reset: assert `rst` = 0 during APPLY → `jk_j`/`jk_k` drop to 0 asynchronously and no `ack` is produced. After release, the pending `req` is re-served from `ptr` = 0.
